// File: rtl/button_debounce.sv
// Push-button conditioner: multi-stage synchronizer followed by a stability-qualifying FSM.
// oSig only changes after the synchronized input has held a new level for STABLE_CYCLES clocks.
module button_debounce #(
   parameter int STABLE_CYCLES = 1_000_000,
   parameter int SYNC_STAGES   = 2
) (
   input  logic iClk,
   input  logic iRst,
   input  logic iSig,
   output logic oSig,
   output logic oBusy,
   output logic oGlitch
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_LOW,
      S_RISE,
      S_HIGH,
      S_FALL
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;

   state_t                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   sig_q;
   logic                   busy_q;
   logic                   glitch_q;

   // NOTE: only the last stage feeds logic; the earlier stages exist to absorb metastability.
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], iSig};
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state_q  <= S_LOW;
         cnt_q    <= '0;
         sig_q    <= 1'b0;
         busy_q   <= 1'b0;
         glitch_q <= 1'b0;
      end else begin
         glitch_q <= 1'b0;
         case (state_q)
            S_LOW: begin
               if (sync) begin
                  state_q <= S_RISE;
                  cnt_q   <= CNT_W'(1);
                  busy_q  <= 1'b1;
               end else begin
                  cnt_q   <= '0;
               end
            end
            // A reversion is checked before the count, so it wins on the qualifying edge.
            S_RISE: begin
               if (!sync) begin
                  state_q  <= S_LOW;
                  cnt_q    <= '0;
                  busy_q   <= 1'b0;
                  glitch_q <= 1'b1;
               end else if (cnt_q == CNT_LAST) begin
                  state_q  <= S_HIGH;
                  cnt_q    <= '0;
                  busy_q   <= 1'b0;
                  sig_q    <= 1'b1;
               end else begin
                  cnt_q    <= cnt_q + 1'b1;
               end
            end
            S_HIGH: begin
               if (!sync) begin
                  state_q <= S_FALL;
                  cnt_q   <= CNT_W'(1);
                  busy_q  <= 1'b1;
               end else begin
                  cnt_q   <= '0;
               end
            end
            S_FALL: begin
               if (sync) begin
                  state_q  <= S_HIGH;
                  cnt_q    <= '0;
                  busy_q   <= 1'b0;
                  glitch_q <= 1'b1;
               end else if (cnt_q == CNT_LAST) begin
                  state_q  <= S_LOW;
                  cnt_q    <= '0;
                  busy_q   <= 1'b0;
                  sig_q    <= 1'b0;
               end else begin
                  cnt_q    <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= S_LOW;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
               sig_q   <= 1'b0;
            end
         endcase
      end
   end

   assign oSig    = sig_q;
   assign oBusy   = busy_q;
   assign oGlitch = glitch_q;

endmodule
